// File: rtl/hsi_tx_sched_pkg.sv
// ============================================================================
// Module   : hsi_tx_sched_pkg
// Purpose  : Shared state encoding, buffer-select codes and message lengths
//            for the HSI transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hsi_tx_sched_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] ST_OFFER = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    localparam logic SEL_TM = 1'b0;
    localparam logic SEL_SR = 1'b1;

    // Same 4 + 62 + 2 frame layout the timing generator uses for CCW_TX_TIME
    localparam int FRAME_SVC_BYTES  = 4;
    localparam int FRAME_DATA_BYTES = 62;
    localparam int FRAME_CRC_BYTES  = 2;
    localparam int TM_FRAME_LEN     = FRAME_SVC_BYTES + FRAME_DATA_BYTES + FRAME_CRC_BYTES;
    localparam int SR_FRAME_LEN     = 8;

endpackage

`default_nettype wire

// File: rtl/hsi_tx_byte_tmo.sv
// ============================================================================
// Module   : hsi_tx_byte_tmo
// Purpose  : Per-byte stall counter; expire marks the BYTE_TMO-th stalled cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsi_tx_byte_tmo #(
    parameter int BYTE_TMO = 4095,
    parameter int TMO_W    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stall,
    output logic expire
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BYTE_TMO - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires while the last permitted stall cycle is in progress
    assign expire = stall && (cnt_q == TMO_LAST);

endmodule

`default_nettype wire

// File: rtl/hsi_tx_sched.sv
// ============================================================================
// Module   : hsi_tx_sched
// Purpose  : Arbitrates TM / SR transmit requests and streams the granted
//            buffer byte by byte into the HSI byte transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsi_tx_sched
    import hsi_tx_sched_pkg::*;
#(
    parameter int TM_LEN   = TM_FRAME_LEN,
    parameter int SR_LEN   = SR_FRAME_LEN,
    parameter int ADDR_W   = 7,
    parameter int BYTE_TMO = 4095,
    parameter int TMO_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tm_tx_rdy,
    output logic              tm_tx_ack,
    input  logic              sr_tx_rdy,
    output logic              sr_tx_ack,
    input  logic              pre_tm,
    output logic              buf_sel,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              msg_done,
    output logic              tmo_err
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  last_idx_q, last_idx_d;
    logic               sel_q, sel_d;
    logic [7:0]         byte_data_q, byte_data_d;

    logic grant_tm;
    logic grant_sr;
    logic handshake;
    logic tmo_start;
    logic tmo_stall;
    logic tmo_expire;

    // TM always wins; SR is held off during the pre-telemetry guard window
    always_comb begin
        grant_tm  = (state_q == ST_IDLE) && tm_tx_rdy;
        grant_sr  = (state_q == ST_IDLE) && !tm_tx_rdy && sr_tx_rdy && !pre_tm;
        handshake = (state_q == ST_OFFER) && byte_ready;
        tmo_start = (state_q == ST_LOAD);
        tmo_stall = (state_q == ST_OFFER) && !byte_ready;
    end

    hsi_tx_byte_tmo #(
        .BYTE_TMO (BYTE_TMO),
        .TMO_W    (TMO_W)
    ) u_byte_tmo (
        .clk    (clk),
        .rst    (rst),
        .start  (tmo_start),
        .stall  (tmo_stall),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            last_idx_q  <= '0;
            sel_q       <= SEL_TM;
            byte_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            sel_q       <= sel_d;
            byte_data_q <= byte_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_tm || grant_sr) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_OFFER;
            ST_OFFER: begin
                if (handshake) begin
                    state_d = (idx_q == last_idx_q) ? ST_DONE : ST_FETCH;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Index is cleared on every grant too, since a timeout abort skips DONE
    always_comb begin
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        sel_d       = sel_q;
        byte_data_d = byte_data_q;
        if (grant_tm) begin
            sel_d      = SEL_TM;
            last_idx_d = ADDR_W'(TM_LEN - 1);
            idx_d      = '0;
        end else if (grant_sr) begin
            sel_d      = SEL_SR;
            last_idx_d = ADDR_W'(SR_LEN - 1);
            idx_d      = '0;
        end
        if (state_q == ST_LOAD) begin
            byte_data_d = buf_data;
        end
        if (handshake) begin
            idx_d = idx_q + ADDR_W'(1);
        end
        if (state_q == ST_DONE) begin
            idx_d = '0;
        end
    end

    always_comb begin
        tm_tx_ack  = grant_tm && !rst;
        sr_tx_ack  = grant_sr && !rst;
        buf_sel    = sel_q;
        buf_addr   = idx_q;
        byte_data  = byte_data_q;
        byte_valid = (state_q == ST_OFFER);
        busy       = (state_q != ST_IDLE);
        msg_done   = (state_q == ST_DONE);
        tmo_err    = (state_q == ST_OFFER) && tmo_expire;
    end

endmodule

`default_nettype wire

// File: tb/tb_hsi_tx_sched.sv
// ============================================================================
// Module   : tb_hsi_tx_sched
// Purpose  : Self-checking bench for hsi_tx_sched against a message-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsi_tx_sched;

    localparam int TM_N     = 68;
    localparam int SR_N     = 8;
    localparam int TMO_CYC  = 4095;
    localparam int EV_TMACK = 1;
    localparam int EV_SRACK = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_TMO   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tm_tx_rdy, sr_tx_rdy, pre_tm, byte_ready;
    logic       tm_tx_ack, sr_tx_ack, buf_sel, byte_valid, busy, msg_done, tmo_err;
    logic [6:0] buf_addr;
    logic [7:0] buf_data = 8'h00;
    logic [7:0] byte_data;

    logic [7:0] tm_mem [128];
    logic [7:0] sr_mem [128];

    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int         acc_cyc[$];
    int         ev_code[$];
    int         ev_cyc[$];
    int         exp_ev[$];

    int   n_pass = 0, n_total = 0, n_fail = 0;
    int   cyc = 0, rdy_mode = 0;
    int   stall_run = 0, tmo_seen = 0, stab_err = 0, ovl_err = 0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int   fall_cyc;

    hsi_tx_sched dut (
        .clk        (clk),
        .rst        (rst),
        .tm_tx_rdy  (tm_tx_rdy),
        .tm_tx_ack  (tm_tx_ack),
        .sr_tx_rdy  (sr_tx_rdy),
        .sr_tx_ack  (sr_tx_ack),
        .pre_tm     (pre_tm),
        .buf_sel    (buf_sel),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .msg_done   (msg_done),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read message buffers
    always @(posedge clk) buf_data <= buf_sel ? sr_mem[buf_addr] : tm_mem[buf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, drive just after posedge
    task automatic tick();
        bit clr_tm, clr_sr;
        @(negedge clk);
        cyc    = cyc + 1;
        clr_tm = tm_tx_ack;
        clr_sr = sr_tx_ack;
        if (tm_tx_ack) begin ev_code.push_back(EV_TMACK); ev_cyc.push_back(cyc); end
        if (sr_tx_ack) begin ev_code.push_back(EV_SRACK); ev_cyc.push_back(cyc); end
        if (msg_done)  begin ev_code.push_back(EV_DONE);  ev_cyc.push_back(cyc); end
        if (byte_valid && !byte_ready) stall_run = stall_run + 1;
        else stall_run = 0;
        if (tmo_err) begin ev_code.push_back(EV_TMO); ev_cyc.push_back(cyc); tmo_seen = stall_run; end
        if (byte_valid && byte_ready) begin got.push_back({buf_sel, byte_data}); acc_cyc.push_back(cyc); end
        if (prev_stall && byte_valid && (byte_data !== prev_data)) stab_err = stab_err + 1;
        prev_stall = byte_valid && !byte_ready;
        prev_data  = byte_data;
        if ((tm_tx_ack || sr_tx_ack) && busy) ovl_err = ovl_err + 1;
        if (tm_tx_ack && sr_tx_ack) ovl_err = ovl_err + 1;
        @(posedge clk);
        #1;
        if (clr_tm) tm_tx_rdy = 1'b0;
        if (clr_sr) sr_tx_rdy = 1'b0;
        case (rdy_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(0, 3) != 0);
            default: byte_ready = 1'b0;
        endcase
    endtask

    function automatic bit quiet();
        return !busy && !tm_tx_rdy && !(sr_tx_rdy && !pre_tm);
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin tick(); n = n + 1; end while (!quiet() && n < budget);
        chk({tag, "_finish"}, 32'(quiet()), 32'd1);
    endtask

    task automatic clear_logs();
        got.delete(); acc_cyc.delete(); ev_code.delete(); ev_cyc.delete();
        exp_q.delete(); exp_ev.delete();
    endtask

    task automatic exp_msg(input bit sel, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({sel, sel ? sr_mem[i] : tm_mem[i]});
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic cmp_events(input string tag);
        chk({tag, "_nevents"}, 32'(ev_code.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < ev_code.size(); i++)
            chk($sformatf("%s_event%0d", tag, i), 32'(ev_code[i]), 32'(exp_ev[i]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tm_ack"},     32'(tm_tx_ack),  32'd0);
        chk({tag, "_sr_ack"},     32'(sr_tx_ack),  32'd0);
        chk({tag, "_buf_sel"},    32'(buf_sel),    32'd0);
        chk({tag, "_buf_addr"},   32'(buf_addr),   32'd0);
        chk({tag, "_byte_data"},  32'(byte_data),  32'd0);
        chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_msg_done"},   32'(msg_done),   32'd0);
        chk({tag, "_tmo_err"},    32'(tmo_err),    32'd0);
    endtask

    initial begin
        rst = 1'b1; tm_tx_rdy = 1'b1; sr_tx_rdy = 1'b1; pre_tm = 1'b0; byte_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            tm_mem[i] = (i < TM_N) ? 8'(i) : 8'h00;
            sr_mem[i] = 8'($urandom_range(0, 255));
        end

        // Reset holds every output low even with both requests raised
        tick(); tick();
        chk_zero("reset");
        tm_tx_rdy = 1'b0; sr_tx_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // TM alone, incrementing buffer, always-ready transmitter
        clear_logs();
        tm_tx_rdy = 1'b1;
        wait_idle("tm_alone", 1000);
        exp_msg(1'b0, TM_N);
        exp_ev = '{EV_TMACK, EV_DONE};
        cmp_stream("tm_alone");
        cmp_events("tm_alone");
        if (ev_cyc.size() == 2 && acc_cyc.size() == TM_N) begin
            chk("tm_alone_first_lat", 32'(acc_cyc[0]), 32'(ev_cyc[0] + 3));
            chk("tm_alone_last_lat",  32'(acc_cyc[TM_N-1]), 32'(ev_cyc[0] + 3 * TM_N));
            chk("tm_alone_done_lat",  32'(ev_cyc[1]), 32'(acc_cyc[TM_N-1] + 1));
        end
        chk("tm_alone_busy_after", 32'(busy), 32'd0);

        for (int i = 0; i < 128; i++) tm_mem[i] = 8'($urandom_range(0, 255));

        // Simultaneous requests, random back-pressure
        clear_logs();
        rdy_mode  = 1;
        tm_tx_rdy = 1'b1; sr_tx_rdy = 1'b1;
        wait_idle("both", 3000);
        exp_msg(1'b0, TM_N); exp_msg(1'b1, SR_N);
        exp_ev = '{EV_TMACK, EV_DONE, EV_SRACK, EV_DONE};
        cmp_stream("both");
        cmp_events("both");
        if (ev_cyc.size() >= 3) chk("both_sr_after_done", 32'(ev_cyc[2]), 32'(ev_cyc[1] + 1));

        // SR held through guard window, TM overtakes, SR granted when guard falls
        clear_logs();
        sr_tx_rdy = 1'b1; pre_tm = 1'b1;
        repeat (500) tick();
        chk("guard_no_ack", 32'(ev_code.size()), 32'd0);
        tm_tx_rdy = 1'b1;
        wait_idle("guard_tm", 3000);
        repeat (10) tick();
        chk("guard_sr_still_held", 32'(sr_tx_rdy), 32'd1);
        pre_tm   = 1'b0;
        fall_cyc = cyc;
        wait_idle("guard_sr", 1000);
        exp_msg(1'b0, TM_N); exp_msg(1'b1, SR_N);
        exp_ev = '{EV_TMACK, EV_DONE, EV_SRACK, EV_DONE};
        cmp_stream("guard");
        cmp_events("guard");
        if (ev_cyc.size() >= 3) chk("guard_sr_ack_cycle", 32'(ev_cyc[2]), 32'(fall_cyc + 1));

        // TM raised at SR byte 3 waits for SR to finish
        clear_logs();
        rdy_mode  = 0;
        sr_tx_rdy = 1'b1;
        for (int n = 0; n < 100 && got.size() < 3; n++) tick();
        tm_tx_rdy = 1'b1;
        wait_idle("nopreempt", 2000);
        exp_msg(1'b1, SR_N); exp_msg(1'b0, TM_N);
        exp_ev = '{EV_SRACK, EV_DONE, EV_TMACK, EV_DONE};
        cmp_stream("nopreempt");
        cmp_events("nopreempt");
        if (ev_cyc.size() >= 3) chk("nopreempt_tm_after_done", 32'(ev_cyc[2]), 32'(ev_cyc[1] + 1));

        // Byte timeout during byte 5
        clear_logs();
        tm_tx_rdy = 1'b1;
        for (int n = 0; n < 100 && got.size() < 5; n++) tick();
        rdy_mode   = 2;
        byte_ready = 1'b0;
        wait_idle("tmo", TMO_CYC + 200);
        exp_msg(1'b0, 5);
        exp_ev = '{EV_TMACK, EV_TMO};
        cmp_stream("tmo");
        cmp_events("tmo");
        chk("tmo_stall_cycles", 32'(tmo_seen), 32'(TMO_CYC));
        chk("tmo_valid_dropped", 32'(byte_valid), 32'd0);
        rdy_mode = 0;
        tick();

        // Asynchronous reset in the middle of a TM frame
        clear_logs();
        tm_tx_rdy = 1'b1;
        for (int n = 0; n < 200 && got.size() < 20; n++) tick();
        chk("rst_pre_nbytes", 32'(got.size()), 32'd20);
        if (got.size() > 0) chk("rst_pre_first", 32'(got[0]), 32'(tm_mem[0]));
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_logs();
        tm_tx_rdy = 1'b1;
        wait_idle("restart", 1000);
        exp_msg(1'b0, TM_N);
        exp_ev = '{EV_TMACK, EV_DONE};
        cmp_stream("restart");
        cmp_events("restart");

        chk("data_stable_while_stalled", 32'(stab_err), 32'd0);
        chk("no_overlapping_grants",     32'(ovl_err),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
